// File: rtl/wb_reg_file.sv
// Write-back stage of the MIPS pipeline. It selects the write-back value and commits it to a
// 32-entry register file with a hardwired r0, two bypassed async read ports and a commit counter.
module wb_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [DATA_WIDTH-1:0] MemoryData,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [ADDR_WIDTH-1:0] RegWriteAdd,
  input  logic [ADDR_WIDTH-1:0] ReadAdd1,
  input  logic [ADDR_WIDTH-1:0] ReadAdd2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] WriteData_Out,
  output logic [31:0]           WriteCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [31:0]           write_count_q;
  logic [31:0]           write_count_d;
  logic                  commit;

  // An X on RegWrite evaluates false in the if below, so undriven inputs cannot commit.
  always_comb begin
    WriteData_Out = MemtoReg ? MemoryData : ALUResult;
    commit        = RegWrite && (RegWriteAdd != '0);
    write_count_d = write_count_q + 32'd1;
  end

  // Address 0 is decoded before the bypass so r0 reads as zero even during a write to it.
  always_comb begin
    ReadData1 = '0;
    if (ReadAdd1 == '0)
      ReadData1 = '0;
    else if (commit && (RegWriteAdd == ReadAdd1))
      ReadData1 = WriteData_Out;
    else
      ReadData1 = regs_q[ReadAdd1];
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadAdd2 == '0)
      ReadData2 = '0;
    else if (commit && (RegWriteAdd == ReadAdd2))
      ReadData2 = WriteData_Out;
    else
      ReadData2 = regs_q[ReadAdd2];
  end

  // NOTE: the whole array is cleared by reset because software may read any register right after
  // reset; this costs a reset on each flop, so it keeps the file as flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
      write_count_q <= '0;
    end else if (commit) begin
      regs_q[RegWriteAdd] <= WriteData_Out;
      write_count_q       <= write_count_d;
    end
  end

  assign WriteCount = write_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: a directed vector table, hand-written reset, X and wrap
// sequences, and a randomized run that is compared against an array-based reference model.
module tb_wb_reg_file;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] MemoryData;
  logic [31:0] ALUResult;
  logic [4:0]  RegWriteAdd;
  logic [4:0]  ReadAdd1;
  logic [4:0]  ReadAdd2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData_Out;
  logic [31:0] WriteCount;

  int passed = 0;
  int total  = 0;

  wb_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .MemoryData   (MemoryData),
    .ALUResult    (ALUResult),
    .RegWriteAdd  (RegWriteAdd),
    .ReadAdd1     (ReadAdd1),
    .ReadAdd2     (ReadAdd2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WriteData_Out(WriteData_Out),
    .WriteCount   (WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_wd;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [6];

  // Reference model: architectural register contents and the retired-write count.
  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] md, input logic [31:0] alu,
                       input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2);
    RegWrite = rw; MemtoReg = m2r; MemoryData = md; ALUResult = alu;
    RegWriteAdd = wa; ReadAdd1 = ra1; ReadAdd2 = ra2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Put some state in, then pulse reset in the middle of a low phase.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'hCAFE_0005, 5'd5, 5'd5, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    #1 check("pre_reset_r5", ReadData1, 32'hCAFE_0005);
    #1 rst = 1'b1;
    #1 check("reset_count", WriteCount, 32'h0);
    check("reset_rd1_r5", ReadData1, 32'h0);
    for (int i = 1; i < 32; i++) begin
      ReadAdd2 = 5'(i);
      #0.1 check($sformatf("reset_r%0d", i), ReadData2, 32'h0);
    end
    rst = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_AAAA, 32'h0000_1234, 5'd8, 5'd8, 5'd0,
                32'h0000_1234, 32'h0000_1234, 32'h0, 32'd0};
    vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd8, 5'd9,
                32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 32'd1};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd9,
                32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'd2};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0000_5555, 5'd8, 5'd8, 5'd8,
                32'h0000_5555, 32'h0000_1234, 32'h0000_1234, 32'd2};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd8, 5'd8, 5'd8,
                32'h0000_0077, 32'h0000_0077, 32'h0000_0077, 32'd2};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0042, 32'h0, 5'd0, 5'd8, 5'd9,
                32'h0000_0042, 32'h0000_0077, 32'hDEAD_BEEF, 32'd3};

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      drive(vecs[v].rw, vecs[v].m2r, vecs[v].md, vecs[v].alu, vecs[v].wa, vecs[v].ra1, vecs[v].ra2);
      #1;
      check($sformatf("vec%0d_wd", v),  WriteData_Out, vecs[v].e_wd);
      check($sformatf("vec%0d_rd1", v), ReadData1,     vecs[v].e_rd1);
      check($sformatf("vec%0d_rd2", v), ReadData2,     vecs[v].e_rd2);
      check($sformatf("vec%0d_cnt", v), WriteCount,    vecs[v].e_cnt);
    end

    // Reset asserted across a write edge: the write must not commit.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0ABC, 5'd3, 5'd3, 5'd8);
    rst = 1'b1;
    #1 check("rst_bypass_rd1", ReadData1, 32'h0000_0ABC);
    check("rst_rd2_r8", ReadData2, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    #1 check("rst_mid_write_r3", ReadData1, 32'h0);
    check("rst_mid_write_cnt", WriteCount, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      logic        rw, m2r;
      logic [31:0] md, alu, wd;
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] after_edge [32];
      @(negedge clk);
      rw  = ($urandom_range(0, 3) != 0);
      m2r = 1'($urandom);
      md  = $urandom;
      alu = $urandom;
      wa  = (n % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra1 = (n % 4 == 1) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      drive(rw, m2r, md, alu, wa, ra1, ra2);
      wd = m2r ? md : alu;
      // A same-cycle write is seen by readers, so reads return the post-commit register view.
      after_edge = model_regs;
      if (rw) after_edge[wa] = wd;
      after_edge[0] = 32'h0;
      #1;
      check("rnd_wd",  WriteData_Out, wd);
      check("rnd_rd1", ReadData1, after_edge[ra1]);
      check("rnd_rd2", ReadData2, after_edge[ra2]);
      check("rnd_cnt", WriteCount, model_cnt);
      @(posedge clk);
      if (rw && wa != 5'd0) model_cnt = model_cnt + 32'd1;
      model_regs = after_edge;
    end

    // X on every data/control input while RegWrite=0 must leave state alone.
    @(negedge clk);
    drive(1'b0, 1'bx, 32'hx, 32'hx, 5'hx, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    #1 check("x_cnt", WriteCount, model_cnt);
    check("x_r1", ReadData1, model_regs[1]);
    check("x_r2", ReadData2, model_regs[2]);

    // Counter wrap: preload the counter, then one commit.
    @(negedge clk);
    force dut.write_count_q = 32'hFFFF_FFFF;
    #1 release dut.write_count_q;
    #1 check("wrap_preload", WriteCount, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0101, 5'd12, 5'd12, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd0);
    #1 check("wrap_cnt", WriteCount, 32'h0);
    check("wrap_r12", ReadData1, 32'h0000_0101);

    do_reset();
    #1 check("final_reset_cnt", WriteCount, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
